// File: rtl/itype_detector_mp.sv
// Per-port E-trace itype classifier with pending-interrupt attach and a
// one-entry skid buffer towards the trace encoder.

package mure_pkg;
  typedef enum logic [2:0] {
    NoCF   = 3'd0,
    Branch = 3'd1,
    Jump   = 3'd2,
    JumpR  = 3'd3,
    Return = 3'd4
  } cf_t;
endpackage

module itype_detector_mp #(
  parameter int NrCommitPorts = 2,
  parameter int ITYPE_LEN     = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 commit_valid_i,
  output logic                                 ready_o,
  input  logic [NrCommitPorts-1:0]             commit_instr_valid_i,
  input  logic                                 commit_ex_valid_i,
  input  logic                                 interrupt_i,
  input  logic [NrCommitPorts-1:0]             eret_i,
  input  mure_pkg::cf_t [NrCommitPorts-1:0]    branch_type_i,
  input  logic [NrCommitPorts-1:0]             branch_taken_i,
  input  logic [NrCommitPorts-1:0]             is_call_i,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic [NrCommitPorts*ITYPE_LEN-1:0]   itype_o,
  output logic [NrCommitPorts-1:0]             iretire_o,
  output logic                                 lost_o
);
  import mure_pkg::*;

  localparam int IdxW  = (NrCommitPorts > 1) ? $clog2(NrCommitPorts) : 1;
  localparam int BundW = NrCommitPorts * ITYPE_LEN;

  generate
    if (ITYPE_LEN != 3 && ITYPE_LEN != 4) begin : g_bad_itype_len
      $error("itype_detector_mp: ITYPE_LEN must be 3 or 4");
    end
    if (NrCommitPorts < 1 || NrCommitPorts > 4) begin : g_bad_ports
      $error("itype_detector_mp: NrCommitPorts must be 1..4");
    end
  endgenerate

  // First matching rule wins; non-retiring ports always report STD.
  function automatic logic [ITYPE_LEN-1:0] classify(
    input logic is_port0,
    input logic retire,
    input logic ex,
    input logic irq,
    input logic eret,
    input cf_t  bt,
    input logic taken,
    input logic call
  );
    logic [3:0] code;
    code = 4'd0;
    if (!retire) begin
      code = 4'd0;
    end else if (is_port0 && ex) begin
      code = 4'd1;
    end else if (irq) begin
      code = 4'd2;
    end else if (eret) begin
      code = 4'd3;
    end else begin
      case (bt)
        Branch:  code = taken ? 4'd5 : 4'd4;
        Jump:    code = (ITYPE_LEN == 4) ? (call ? 4'd9 : 4'd11) : 4'd0;
        JumpR:   code = (ITYPE_LEN == 4) ? (call ? 4'd8 : 4'd10) : 4'd6;
        Return:  code = (ITYPE_LEN == 4) ? 4'd13 : 4'd6;
        default: code = 4'd0;
      endcase
    end
    return code[ITYPE_LEN-1:0];
  endfunction

  logic                     out_valid_r;
  logic [BundW-1:0]         out_itype_r;
  logic [NrCommitPorts-1:0] out_iretire_r;
  logic                     skid_full_r;
  logic [BundW-1:0]         skid_itype_r;
  logic [NrCommitPorts-1:0] skid_iretire_r;
  logic                     int_pend_r;
  logic                     lost_r;

  logic                     accept_s;
  logic                     irq_req_s;
  logic                     last_valid_s;
  logic [IdxW-1:0]          last_idx_s;
  logic                     attach_s;
  logic [BundW-1:0]         new_itype_s;
  logic                     int_pend_nxt_s;

  assign ready_o   = !skid_full_r;
  assign accept_s  = commit_valid_i && !skid_full_r;
  assign irq_req_s = interrupt_i || int_pend_r;

  // Locate the last retiring port: the interrupt is reported after it.
  always_comb begin
    last_valid_s = 1'b0;
    last_idx_s   = '0;
    for (int p = 0; p < NrCommitPorts; p++) begin
      if (commit_instr_valid_i[p]) begin
        last_valid_s = 1'b1;
        last_idx_s   = IdxW'(p);
      end else begin
        last_valid_s = last_valid_s;
      end
    end
  end

  // An EXC on port 0 cannot also carry the INT, so the request waits.
  assign attach_s = accept_s && irq_req_s && last_valid_s &&
                    !((last_idx_s == '0) && commit_ex_valid_i);

  assign int_pend_nxt_s = attach_s ? 1'b0 : (interrupt_i ? 1'b1 : int_pend_r);

  // Classify every port of the incoming bundle.
  always_comb begin
    new_itype_s = '0;
    for (int p = 0; p < NrCommitPorts; p++) begin
      new_itype_s[p*ITYPE_LEN +: ITYPE_LEN] = classify(
        (p == 0), commit_instr_valid_i[p], commit_ex_valid_i,
        attach_s && (last_idx_s == IdxW'(p)), eret_i[p],
        branch_type_i[p], branch_taken_i[p], is_call_i[p]);
    end
  end

  // Output register plus skid entry; skid has priority when the output frees.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_r    <= 1'b0;
      out_itype_r    <= '0;
      out_iretire_r  <= '0;
      skid_full_r    <= 1'b0;
      skid_itype_r   <= '0;
      skid_iretire_r <= '0;
      int_pend_r     <= 1'b0;
      lost_r         <= 1'b0;
    end else begin
      lost_r     <= commit_valid_i && skid_full_r;
      int_pend_r <= int_pend_nxt_s;
      if (!out_valid_r || ready_i) begin
        if (skid_full_r) begin
          out_valid_r   <= 1'b1;
          out_itype_r   <= skid_itype_r;
          out_iretire_r <= skid_iretire_r;
          skid_full_r   <= 1'b0;
        end else if (accept_s) begin
          out_valid_r   <= 1'b1;
          out_itype_r   <= new_itype_s;
          out_iretire_r <= commit_instr_valid_i;
        end else begin
          out_valid_r   <= 1'b0;
        end
      end else if (accept_s) begin
        skid_full_r    <= 1'b1;
        skid_itype_r   <= new_itype_s;
        skid_iretire_r <= commit_instr_valid_i;
      end else begin
        skid_full_r    <= skid_full_r;
      end
    end
  end

  assign valid_o   = out_valid_r;
  assign itype_o   = out_itype_r;
  assign iretire_o = out_iretire_r;
  assign lost_o    = lost_r;

endmodule

// File: tb/tb_itype_detector_mp.sv
// Bench for itype_detector_mp: directed scenarios plus random traffic
// against a queue-based reference model, on ITYPE_LEN=3 and 4 instances.

module tb_itype_detector_mp;
  import mure_pkg::*;

  localparam int NP = 2;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  logic           commit_valid = 1'b0;
  logic [NP-1:0]  instr_valid = '0;
  logic           ex_valid = 1'b0;
  logic           interrupt = 1'b0;
  logic [NP-1:0]  eret = '0;
  cf_t  [NP-1:0]  btype;
  logic [NP-1:0]  taken = '0;
  logic [NP-1:0]  call = '0;
  logic           ready_in = 1'b1;

  logic           ready3, valid3, lost3;
  logic [NP*3-1:0] itype3;
  logic [NP-1:0]  iretire3;
  logic           ready4, valid4, lost4;
  logic [NP*4-1:0] itype4;
  logic [NP-1:0]  iretire4;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [NP*3-1:0] it3;
    logic [NP*4-1:0] it4;
    logic [NP-1:0]   ir;
  } exp_t;

  exp_t q[$];
  bit   m_pend = 1'b0;
  bit   exp_lost = 1'b0;

  always #5 clk = ~clk;

  itype_detector_mp #(.NrCommitPorts(NP), .ITYPE_LEN(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .commit_valid_i(commit_valid), .ready_o(ready3),
    .commit_instr_valid_i(instr_valid), .commit_ex_valid_i(ex_valid),
    .interrupt_i(interrupt), .eret_i(eret), .branch_type_i(btype),
    .branch_taken_i(taken), .is_call_i(call), .valid_o(valid3), .ready_i(ready_in),
    .itype_o(itype3), .iretire_o(iretire3), .lost_o(lost3));

  itype_detector_mp #(.NrCommitPorts(NP), .ITYPE_LEN(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_ni), .commit_valid_i(commit_valid), .ready_o(ready4),
    .commit_instr_valid_i(instr_valid), .commit_ex_valid_i(ex_valid),
    .interrupt_i(interrupt), .eret_i(eret), .branch_type_i(btype),
    .branch_taken_i(taken), .is_call_i(call), .valid_o(valid4), .ready_i(ready_in),
    .itype_o(itype4), .iretire_o(iretire4), .lost_o(lost4));

  // Spec rule table: first match wins.
  function automatic int m_type(int len, int p, logic iv, logic ex, logic intr,
                                logic er, cf_t bt, logic tk, logic cl);
    if (!iv) return 0;
    if (p == 0 && ex) return 1;
    if (intr) return 2;
    if (er) return 3;
    if (bt == Branch) return tk ? 5 : 4;
    if (len == 3) return (bt == JumpR || bt == Return) ? 6 : 0;
    if (bt == JumpR) return cl ? 8 : 10;
    if (bt == Jump) return cl ? 9 : 11;
    if (bt == Return) return 13;
    return 0;
  endfunction

  // Advance the reference model for the coming edge, then step the clock.
  task automatic tick();
    exp_t e;
    int   last;
    bit   rdy, acc, drn, req, att;
    rdy  = (q.size() < 2);
    acc  = commit_valid && rdy;
    drn  = (q.size() > 0) && ready_in;
    last = -1;
    for (int p = 0; p < NP; p++) if (instr_valid[p]) last = p;
    req = interrupt || m_pend;
    att = acc && req && (last >= 0) && !(last == 0 && ex_valid);
    for (int p = 0; p < NP; p++) begin
      e.it3[p*3 +: 3] = 3'(m_type(3, p, instr_valid[p], ex_valid, att && (p == last),
                                  eret[p], btype[p], taken[p], call[p]));
      e.it4[p*4 +: 4] = 4'(m_type(4, p, instr_valid[p], ex_valid, att && (p == last),
                                  eret[p], btype[p], taken[p], call[p]));
    end
    e.ir = instr_valid;
    if (drn) void'(q.pop_front());
    if (acc) q.push_back(e);
    exp_lost = commit_valid && !rdy;
    if (att) m_pend = 1'b0;
    else if (interrupt) m_pend = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic cv, logic [NP-1:0] iv, logic ex, logic irq, logic [NP-1:0] er,
                       cf_t bt1, cf_t bt0, logic [NP-1:0] tk, logic [NP-1:0] cl, logic rdy);
    commit_valid = cv; instr_valid = iv; ex_valid = ex; interrupt = irq; eret = er;
    btype[1] = bt1; btype[0] = bt0; taken = tk; call = cl; ready_in = rdy;
  endtask

  task automatic idle(int n);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, NoCF, NoCF, 2'b00, 2'b00, 1'b1);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({valid3, valid4, lost3, lost4} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_valid_lost: got %b want 0000", {valid3, valid4, lost3, lost4});
    end
    n_cmp++;
    if ({itype3, itype4, iretire3, iretire4} !== 18'h0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", {itype3, itype4, iretire3, iretire4});
    end
    n_cmp++;
    if ({ready3, ready4} !== 2'b11) begin
      n_bad++; $display("FAIL reset_ready: got %b want 11", {ready3, ready4});
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 2'b11, 1'b0, 1'b0, 2'b00, JumpR, Branch, 2'b01, 2'b00, 1'b1);
    tick();
    n_cmp++;
    if ({valid3, itype3, iretire3} !== {1'b1, 3'd6, 3'd5, 2'b11}) begin
      n_bad++; $display("FAIL basic_len3: got %b want %b", {valid3, itype3, iretire3}, {1'b1, 3'd6, 3'd5, 2'b11});
    end
    n_cmp++;
    if ({valid4, itype4} !== {1'b1, 8'hA5}) begin
      n_bad++; $display("FAIL basic_len4: got %h want %h", {valid4, itype4}, {1'b1, 8'hA5});
    end
    idle(2);
  endtask

  task automatic test_itype4();
    drive(1'b1, 2'b11, 1'b0, 1'b0, 2'b00, Return, Jump, 2'b00, 2'b01, 1'b1);
    tick();
    n_cmp++;
    if ({itype4, iretire4} !== {8'hD9, 2'b11}) begin
      n_bad++; $display("FAIL call_return_len4: got %h want %h", {itype4, iretire4}, {8'hD9, 2'b11});
    end
    n_cmp++;
    if (itype3 !== {3'd6, 3'd0}) begin
      n_bad++; $display("FAIL call_return_len3: got %h want %h", itype3, {3'd6, 3'd0});
    end
    drive(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, NoCF, JumpR, 2'b00, 2'b00, 1'b1);
    tick();
    n_cmp++;
    if ({itype4, iretire4} !== {8'h0A, 2'b01}) begin
      n_bad++; $display("FAIL jumpr_len4: got %h want %h", {itype4, iretire4}, {8'h0A, 2'b01});
    end
    n_cmp++;
    if (itype3 !== {3'd0, 3'd6}) begin
      n_bad++; $display("FAIL jumpr_len3: got %h want %h", itype3, {3'd0, 3'd6});
    end
    idle(2);
  endtask

  task automatic test_interrupt();
    drive(1'b0, 2'b00, 1'b0, 1'b1, 2'b00, NoCF, NoCF, 2'b00, 2'b00, 1'b1);
    tick();
    idle(1);
    drive(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, NoCF, NoCF, 2'b00, 2'b00, 1'b1);
    tick();
    n_cmp++;
    if ({itype3, itype4} !== {3'd0, 3'd2, 4'd0, 4'd2}) begin
      n_bad++; $display("FAIL int_attach: got %h want %h", {itype3, itype4}, {3'd0, 3'd2, 4'd0, 4'd2});
    end
    tick();
    n_cmp++;
    if ({valid3, itype3, itype4} !== {1'b1, 6'd0, 8'd0}) begin
      n_bad++; $display("FAIL int_cleared: got %h want %h", {valid3, itype3, itype4}, {1'b1, 6'd0, 8'd0});
    end
    idle(2);
  endtask

  task automatic test_exc_int();
    drive(1'b1, 2'b01, 1'b1, 1'b1, 2'b00, NoCF, NoCF, 2'b00, 2'b00, 1'b1);
    tick();
    n_cmp++;
    if ({itype3, itype4} !== {3'd0, 3'd1, 4'd0, 4'd1}) begin
      n_bad++; $display("FAIL exc_port0: got %h want %h", {itype3, itype4}, {3'd0, 3'd1, 4'd0, 4'd1});
    end
    drive(1'b1, 2'b11, 1'b0, 1'b0, 2'b00, NoCF, NoCF, 2'b00, 2'b00, 1'b1);
    tick();
    n_cmp++;
    if ({itype3, itype4} !== {3'd2, 3'd0, 4'd2, 4'd0}) begin
      n_bad++; $display("FAIL exc_int_deferred: got %h want %h", {itype3, itype4}, {3'd2, 3'd0, 4'd2, 4'd0});
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b11, 1'b0, 1'b0, 2'b00, NoCF, Branch, 2'b01, 2'b00, 1'b0);   // A
    tick();
    drive(1'b1, 2'b11, 1'b0, 1'b0, 2'b10, NoCF, Branch, 2'b00, 2'b00, 1'b0);   // B
    tick();
    n_cmp++;
    if ({ready3, ready4, valid3, itype3} !== {2'b00, 1'b1, 3'd0, 3'd5}) begin
      n_bad++; $display("FAIL skid_full: got %b want %b", {ready3, ready4, valid3, itype3}, {2'b00, 1'b1, 3'd0, 3'd5});
    end
    drive(1'b1, 2'b01, 1'b0, 1'b0, 2'b01, NoCF, NoCF, 2'b00, 2'b00, 1'b0);     // C
    tick();
    n_cmp++;
    if ({lost3, lost4} !== 2'b11) begin
      n_bad++; $display("FAIL lost_pulse: got %b want 11", {lost3, lost4});
    end
    n_cmp++;
    if ({valid4, itype4, iretire4} !== {1'b1, 8'h05, 2'b11}) begin
      n_bad++; $display("FAIL hold_a: got %h want %h", {valid4, itype4, iretire4}, {1'b1, 8'h05, 2'b11});
    end
    drive(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, NoCF, NoCF, 2'b00, 2'b00, 1'b0);
    tick();
    n_cmp++;
    if ({lost3, lost4, itype4} !== {2'b00, 8'h05}) begin
      n_bad++; $display("FAIL lost_once: got %h want %h", {lost3, lost4, itype4}, {2'b00, 8'h05});
    end
    ready_in = 1'b1;
    tick();
    n_cmp++;
    if ({valid3, itype3, itype4, ready3} !== {1'b1, 3'd3, 3'd4, 8'h34, 1'b1}) begin
      n_bad++; $display("FAIL deliver_b: got %h want %h", {valid3, itype3, itype4, ready3}, {1'b1, 3'd3, 3'd4, 8'h34, 1'b1});
    end
    tick();
    n_cmp++;
    if ({valid3, valid4} !== 2'b00) begin
      n_bad++; $display("FAIL drained: got %b want 00", {valid3, valid4});
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'b00, 1'b0, 1'b1, 2'b00, NoCF, NoCF, 2'b00, 2'b00, 1'b0);
    tick();
    drive(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, NoCF, NoCF, 2'b00, 2'b00, 1'b0);
    tick();
    n_cmp++;
    if ({ready3, valid3} !== 2'b01) begin
      n_bad++; $display("FAIL pre_reset_full: got %b want 01", {ready3, valid3});
    end
    drive(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, NoCF, NoCF, 2'b00, 2'b00, 1'b1);
    rst_ni = 1'b0;
    q.delete(); m_pend = 1'b0; exp_lost = 1'b0;
    #2;
    n_cmp++;
    if ({valid3, valid4, ready3, ready4} !== 4'b0011) begin
      n_bad++; $display("FAIL async_reset: got %b want 0011", {valid3, valid4, ready3, ready4});
    end
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, NoCF, NoCF, 2'b00, 2'b00, 1'b1);
    tick();
    n_cmp++;
    if ({valid3, itype3, itype4} !== {1'b1, 6'd0, 8'd0}) begin
      n_bad++; $display("FAIL no_stale_int: got %h want %h", {valid3, itype3, itype4}, {1'b1, 6'd0, 8'd0});
    end
    idle(2);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      commit_valid = ($urandom_range(9, 0) < 7);
      instr_valid  = NP'($urandom);
      ex_valid     = ($urandom_range(7, 0) == 0);
      interrupt    = ($urandom_range(9, 0) == 0);
      for (int p = 0; p < NP; p++) begin
        eret[p]  = ($urandom_range(7, 0) == 0);
        btype[p] = cf_t'(3'($urandom_range(4, 0)));
        taken[p] = 1'($urandom);
        call[p]  = 1'($urandom);
      end
      ready_in = ($urandom_range(9, 0) < 6);
      tick();
      n_cmp++;
      if ({valid3, valid4, ready3, ready4, lost3, lost4} !==
          {{2{q.size() > 0}}, {2{q.size() < 2}}, {2{exp_lost}}}) begin
        n_bad++;
        $display("FAIL rand_ctrl cyc %0d: got %b want %b", c, {valid3, valid4, ready3, ready4, lost3, lost4},
                 {{2{q.size() > 0}}, {2{q.size() < 2}}, {2{exp_lost}}});
      end
      if (q.size() > 0) begin
        n_cmp++;
        if ({itype3, itype4, iretire3, iretire4} !== {q[0].it3, q[0].it4, q[0].ir, q[0].ir}) begin
          n_bad++;
          $display("FAIL rand_data cyc %0d: got %h want %h", c, {itype3, itype4, iretire3, iretire4},
                   {q[0].it3, q[0].it4, q[0].ir, q[0].ir});
        end
      end
    end
    idle(3);
  endtask

  initial begin
    btype = {NoCF, NoCF};
    rst_ni = 1'b0;
    #12;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_itype4();
    test_interrupt();
    test_exc_int();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
